inst_seq_control: RTL and testbench
===================================

Name: inst_seq_control

Overview:
- Next-generation instruction sequencer for the HDC core.
- Holds the instruction memory and the program counter (PC), and supports a parametrised number of nested hardware loops with per-loop iteration counts.
- Issues instructions over a valid/ready handshake instead of a stall input, and signals program completion with a done pulse.
- Sits between the CSR/instruction-load path and the core decoder.

Parameters:
- InstWidth, 32, instruction word width and write-data width.
- InstMemDepth, 128, number of instruction words; AddrW = $clog2(InstMemDepth).
- NumLoops, 4, number of nested loop levels; level 0 is the innermost.
- LoopCntWidth, 16, width of each loop iteration count.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- clr_i, in, 1, synchronous clear of PC, FSM, loop counters and memory.
- start_i, in, 1, start program execution.
- busy_o, out, 1, high while the FSM is in RUN.
- done_o, out, 1, one-cycle pulse at program end.
- wr_mode_i, in, 1, instruction load mode.
- wr_addr_i, in, AddrW, load address.
- wr_addr_en_i, in, 1, load wr_addr_i into the PC.
- wr_data_i, in, InstWidth, instruction word to write.
- wr_data_en_i, in, 1, write mem[PC], then PC+1.
- inst_o, out, InstWidth, mem[PC].
- inst_valid_o, out, 1, instruction valid.
- inst_ready_i, in, 1, consumer ready.
- inst_pc_o, out, AddrW, current PC.
- prog_end_addr_i, in, AddrW, address of the last instruction.
- loop_mode_i, in, $clog2(NumLoops+1), number of active loop levels (0..NumLoops).
- loop_jump_addr_i, in, NumLoops*AddrW, per-level loop start address; level k occupies slice [k*AddrW +: AddrW].
- loop_end_addr_i, in, NumLoops*AddrW, per-level loop end address.
- loop_count_i, in, NumLoops*LoopCntWidth, per-level total iterations.
- dbg_en_i, in, 1, debug freeze.
- dbg_addr_i, in, AddrW, debug read address.
- dbg_data_o, out, InstWidth, mem[dbg_addr_i], combinational.

Behaviour:
- Reset values:
  - FSM = IDLE; PC = 0; all loop counters = 0; all memory words = 0.
  - busy_o = 0; done_o = 0; inst_valid_o = 0.
- FSM states and transitions:
  - IDLE: start_i -> RUN next cycle; PC and loop counters cleared on the same edge.
  - RUN: exit to IDLE on the final fire (defined below).
- Write path:
  - Honoured only in IDLE with wr_mode_i = 1.
  - wr_addr_en_i has priority over wr_data_en_i; PC = wr_addr_i.
  - wr_data_en_i writes mem[PC] = wr_data_i and increments PC.
  - In RUN, writes and wr_addr_en_i are ignored.
- Issue path:
  - inst_valid_o = (state == RUN) && !dbg_en_i.
  - inst_o = mem[PC], combinational, zero latency.
  - fire = inst_valid_o && inst_ready_i.
  - PC and counters change only on fire; valid stays high and inst_o stays stable while ready is low.
- Loop resolution on fire at PC p, for levels k < loop_mode_i:
  - match[k] = (end[k] == p).
  - A count of 0 is treated as 1.
  - exhausted[k] = cnt[k] >= count[k] - 1.
  - Select the lowest k with match[k] && !exhausted[k].
  - If found: PC = jump[k]; cnt[k]++; cnt[j] = 0 for all j < k.
  - Otherwise: cnt[k] = 0 for every matching k; PC = p + 1, wrapping modulo InstMemDepth.
- Program end:
  - Condition: fire at p == prog_end_addr_i and no jump taken.
  - Response: PC is held, state -> IDLE, done_o pulses 1 cycle on the next cycle, busy_o falls on the same edge.
  - A jump at prog_end_addr_i takes priority over the end condition.
- Debug:
  - dbg_en_i freezes the PC, counters and FSM, and deasserts valid.
  - Debug reads are always available.
- Clear:
  - clr_i has the highest priority: same state as reset except done_o = 0, applied on the next edge.
  - clr_i mid-RUN aborts without a done pulse.
- Start is ignored in RUN; start and clr_i together -> clr_i wins.
- Loop configuration inputs must be held stable during RUN; no internal capture.

Test Plan:
- Load: wr_addr 0, write 5 words 0xA0..0xA4; readback via dbg_addr 0..4 -> 0xA0..0xA4; PC = 5 after the writes.
- Linear run: mode 0, prog_end = 4, ready = 1 -> PC sequence 0,1,2,3,4; done_o pulse 1 cycle after fire at 4; busy_o low after.
- Single loop: mode 1, jump0 = 1, end0 = 2, count0 = 3, prog_end = 3 -> PCs 0,1,2,1,2,1,2,3; done.
- Nested loops: mode 2:
  - Config: jump0 = 1, end0 = 1, count0 = 2, jump1 = 0, end1 = 2, count1 = 2, prog_end = 2.
  - Required PCs: 0,1,1,2,0,1,1,2, then done.
- Backpressure/debug: inst_ready_i low for 3 cycles mid-loop, then dbg_en_i for 2 cycles -> PC, counters and inst_o unchanged and valid low during debug; resumes at the same PC.
- Abort: clr_i asserted while PC = 2 in RUN -> next cycle PC = 0, IDLE, memory zeroed, no done_o pulse; start_i together with clr_i -> stays IDLE.

Source files
------------

// File: rtl/inst_seq_control.sv
// ---------------------------------------------------------------------------
// inst_seq_control
//   Instruction sequencer for the HDC core. Owns the instruction memory and
//   the program counter, walks the program with up to NumLoops nested
//   hardware loops, and hands instructions to the decoder over a
//   valid/ready handshake. A one-cycle done pulse marks program completion.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   clr_i                 synchronous clear (PC, FSM, loop counters, memory)
//   start_i, busy_o       start program / high while running
//   done_o                one-cycle pulse after the last instruction fires
//   wr_*                  instruction load path (IDLE + wr_mode_i only)
//   inst_o, inst_valid_o  instruction at PC and its valid flag
//   inst_ready_i          decoder ready
//   inst_pc_o             current PC
//   prog_end_addr_i       address of the last program instruction
//   loop_*                loop configuration, level k at slice k (0 = inner)
//   dbg_en_i              freeze sequencing and drop valid
//   dbg_addr_i/dbg_data_o combinational memory read port
// ---------------------------------------------------------------------------
module inst_seq_control #(
    parameter int InstWidth    = 32,
    parameter int InstMemDepth = 128,
    parameter int NumLoops     = 4,
    parameter int LoopCntWidth = 16,
    localparam int AddrW       = $clog2(InstMemDepth),
    localparam int ModeW       = $clog2(NumLoops + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    input  logic                             wr_mode_i,
    input  logic [AddrW-1:0]                 wr_addr_i,
    input  logic                             wr_addr_en_i,
    input  logic [InstWidth-1:0]             wr_data_i,
    input  logic                             wr_data_en_i,
    output logic [InstWidth-1:0]             inst_o,
    output logic                             inst_valid_o,
    input  logic                             inst_ready_i,
    output logic [AddrW-1:0]                 inst_pc_o,
    input  logic [AddrW-1:0]                 prog_end_addr_i,
    input  logic [ModeW-1:0]                 loop_mode_i,
    input  logic [NumLoops*AddrW-1:0]        loop_jump_addr_i,
    input  logic [NumLoops*AddrW-1:0]        loop_end_addr_i,
    input  logic [NumLoops*LoopCntWidth-1:0] loop_count_i,
    input  logic                             dbg_en_i,
    input  logic [AddrW-1:0]                 dbg_addr_i,
    output logic [InstWidth-1:0]             dbg_data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrW-1:0]        pc_q, pc_d;
    logic                    done_q, done_d;
    logic [LoopCntWidth-1:0] cnt_q [NumLoops];
    logic [LoopCntWidth-1:0] cnt_d [NumLoops];
    logic [InstWidth-1:0]    mem_q [InstMemDepth];

    logic                    mem_we;
    logic                    mem_clr;
    logic [AddrW-1:0]        pc_inc;
    logic [NumLoops-1:0]     match;
    logic                    hit;
    int                      hit_k;
    logic [AddrW-1:0]        jump_pc;

    // PC + 1 with wrap-around, also correct for non power-of-two depths.
    assign pc_inc = (pc_q == AddrW'(InstMemDepth - 1)) ? '0 : pc_q + AddrW'(1);

    // Loop resolution for the current PC. Scanning from the outermost level
    // down leaves the innermost eligible level as the final selection.
    always_comb begin
        logic [LoopCntWidth-1:0] lim;
        match   = '0;
        hit     = 1'b0;
        hit_k   = 0;
        jump_pc = '0;
        lim     = '0;
        for (int k = NumLoops - 1; k >= 0; k--) begin
            if (k < int'(loop_mode_i)) begin
                // A programmed count of 0 behaves as a single pass.
                lim = loop_count_i[k*LoopCntWidth +: LoopCntWidth];
                if (lim == '0) begin
                    lim = LoopCntWidth'(1);
                end
                match[k] = (loop_end_addr_i[k*AddrW +: AddrW] == pc_q);
                if (match[k] && (cnt_q[k] < lim - LoopCntWidth'(1))) begin
                    hit     = 1'b1;
                    hit_k   = k;
                    jump_pc = loop_jump_addr_i[k*AddrW +: AddrW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        mem_clr = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
            pc_d    = '0;
            mem_clr = 1'b1;
            for (int k = 0; k < NumLoops; k++) cnt_d[k] = '0;
        end else if (!dbg_en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = RUN;
                        pc_d    = '0;
                        for (int k = 0; k < NumLoops; k++) cnt_d[k] = '0;
                    end else if (wr_mode_i) begin
                        if (wr_addr_en_i) begin
                            pc_d = wr_addr_i;
                        end else if (wr_data_en_i) begin
                            mem_we = 1'b1;
                            pc_d   = pc_inc;
                        end
                    end
                end
                RUN: begin
                    // Valid is implied here (RUN and no debug), so ready == fire.
                    if (inst_ready_i) begin
                        if (hit) begin
                            pc_d         = jump_pc;
                            cnt_d[hit_k] = cnt_q[hit_k] + LoopCntWidth'(1);
                            for (int j = 0; j < NumLoops; j++) begin
                                if (j < hit_k) cnt_d[j] = '0;
                            end
                        end else begin
                            for (int k = 0; k < NumLoops; k++) begin
                                if (match[k]) cnt_d[k] = '0;
                            end
                            // End of program: PC stays on the last instruction.
                            if (pc_q == prog_end_addr_i) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NumLoops; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            for (int k = 0; k < NumLoops; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // Memory is flop-based so that reset and clear can zero every word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < InstMemDepth; i++) mem_q[i] <= '0;
        end else if (mem_clr) begin
            for (int i = 0; i < InstMemDepth; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[pc_q] <= wr_data_i;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;
    assign inst_valid_o = (state_q == RUN) && !dbg_en_i;
    assign inst_o       = mem_q[pc_q];
    assign inst_pc_o    = pc_q;
    assign dbg_data_o   = mem_q[dbg_addr_i];

endmodule

// File: tb/tb_inst_seq_control.sv
// ---------------------------------------------------------------------------
// tb_inst_seq_control
//   Directed bench for inst_seq_control. Each run pushes the PC sequence it
//   expects into a queue; a monitor pops one entry per handshake and checks
//   PC and instruction word. Program word at address p is 0xA0 + p.
// ---------------------------------------------------------------------------
module tb_inst_seq_control;

    localparam int AddrW = 7;
    localparam int ModeW = 3;
    localparam int NL    = 4;
    localparam int CW    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_i, start_i, busy_o, done_o;
    logic              wr_mode_i, wr_addr_en_i, wr_data_en_i;
    logic [AddrW-1:0]  wr_addr_i;
    logic [31:0]       wr_data_i;
    logic [31:0]       inst_o;
    logic              inst_valid_o, inst_ready_i;
    logic [AddrW-1:0]  inst_pc_o, prog_end_addr_i;
    logic [ModeW-1:0]  loop_mode_i;
    logic [NL*AddrW-1:0] loop_jump_addr_i, loop_end_addr_i;
    logic [NL*CW-1:0]  loop_count_i;
    logic              dbg_en_i;
    logic [AddrW-1:0]  dbg_addr_i;
    logic [31:0]       dbg_data_o;

    inst_seq_control dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .wr_mode_i(wr_mode_i),
        .wr_addr_i(wr_addr_i), .wr_addr_en_i(wr_addr_en_i),
        .wr_data_i(wr_data_i), .wr_data_en_i(wr_data_en_i),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_pc_o(inst_pc_o),
        .prog_end_addr_i(prog_end_addr_i), .loop_mode_i(loop_mode_i),
        .loop_jump_addr_i(loop_jump_addr_i), .loop_end_addr_i(loop_end_addr_i),
        .loop_count_i(loop_count_i), .dbg_en_i(dbg_en_i),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_q[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int last_fire_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per handshake, plus done tracking.
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_valid_o && inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fire_pc", 32'(inst_pc_o), 32'hFFFF_FFFF);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("fire_pc", 32'(inst_pc_o), 32'(e));
                    chk("fire_inst", inst_o, 32'hA0 + 32'(e));
                end
                last_fire_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_loop(input int k, input int jmp, input int endp, input int cnt);
        loop_jump_addr_i[k*AddrW +: AddrW] = AddrW'(jmp);
        loop_end_addr_i[k*AddrW +: AddrW]  = AddrW'(endp);
        loop_count_i[k*CW +: CW]           = CW'(cnt);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Wait for the scoreboard to drain and one done pulse, then check the end state.
    task automatic wait_done(input int dc0, input int end_pc);
        int budget = 300;
        while (!(exp_q.size() == 0 && done_cnt > dc0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: got %0d pending, expected 0", exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
        chk("done_pulses", 32'(done_cnt - dc0), 32'd1);
        chk("done_latency", 32'(done_cyc - last_fire_cyc), 32'd1);
        chk("busy_after_done", 32'(busy_o), 32'd0);
        chk("pc_held", 32'(inst_pc_o), 32'(end_pc));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dc0;
        rst_n = 1'b0; clr_i = 0; start_i = 0; wr_mode_i = 0; wr_addr_en_i = 0;
        wr_data_en_i = 0; wr_addr_i = '0; wr_data_i = '0; inst_ready_i = 1'b1;
        prog_end_addr_i = '0; loop_mode_i = '0; loop_jump_addr_i = '0;
        loop_end_addr_i = '0; loop_count_i = '0; dbg_en_i = 0; dbg_addr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_pc", 32'(inst_pc_o), 0);
        chk("rst_mem0", dbg_data_o, 0);

        // Load 0xA0.. at 0..7
        wr_mode_i = 1; wr_addr_i = 0; wr_addr_en_i = 1;
        tick();
        wr_addr_en_i = 0;
        for (int i = 0; i < 8; i++) begin
            wr_data_i = 32'hA0 + 32'(i); wr_data_en_i = 1;
            tick();
            if (i == 4) chk("pc_after_5_writes", 32'(inst_pc_o), 5);
        end
        wr_data_en_i = 0; wr_mode_i = 0;
        for (int i = 0; i < 5; i++) begin
            dbg_addr_i = AddrW'(i);
            #1 chk("readback", dbg_data_o, 32'hA0 + 32'(i));
        end

        // Linear run
        loop_mode_i = 0; prog_end_addr_i = 4;
        exp_q = {0, 1, 2, 3, 4};
        dc0 = done_cnt;
        pulse_start();
        chk("busy_in_run", 32'(busy_o), 1);
        wait_done(dc0, 4);

        // Single loop
        loop_mode_i = 1; set_loop(0, 1, 2, 3); prog_end_addr_i = 3;
        exp_q = {0, 1, 2, 1, 2, 1, 2, 3};
        dc0 = done_cnt;
        pulse_start();
        wait_done(dc0, 3);

        // Nested loops
        loop_mode_i = 2; set_loop(0, 1, 1, 2); set_loop(1, 0, 2, 2); prog_end_addr_i = 2;
        exp_q = {0, 1, 1, 2, 0, 1, 1, 2};
        dc0 = done_cnt;
        pulse_start();
        wait_done(dc0, 2);

        // Count of zero behaves as one pass (no jump)
        loop_mode_i = 1; set_loop(0, 0, 1, 0); set_loop(1, 0, 0, 0); prog_end_addr_i = 2;
        exp_q = {0, 1, 2};
        dc0 = done_cnt;
        pulse_start();
        wait_done(dc0, 2);

        // Backpressure then debug freeze mid-loop
        loop_mode_i = 1; set_loop(0, 1, 2, 3); prog_end_addr_i = 3;
        exp_q = {0, 1, 2, 1, 2, 1, 2, 3};
        dc0 = done_cnt;
        pulse_start();
        repeat (4) tick();
        inst_ready_i = 0;
        chk("fires_before_stall", 32'(exp_q.size()), 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(inst_valid_o), 1);
            chk("stall_pc", 32'(inst_pc_o), 2);
            chk("stall_inst", inst_o, 32'hA2);
            tick();
        end
        inst_ready_i = 1; dbg_en_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("dbg_valid", 32'(inst_valid_o), 0);
            chk("dbg_pc", 32'(inst_pc_o), 2);
            chk("dbg_inst", inst_o, 32'hA2);
            tick();
        end
        dbg_en_i = 0;
        wait_done(dc0, 3);

        // Abort with clear at PC 2
        loop_mode_i = 0; prog_end_addr_i = 7;
        exp_q = {0, 1};
        dc0 = done_cnt;
        pulse_start();
        repeat (2) tick();
        chk("abort_pc_before", 32'(inst_pc_o), 2);
        inst_ready_i = 0; clr_i = 1;
        tick();
        clr_i = 0;
        chk("abort_pc", 32'(inst_pc_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_valid", 32'(inst_valid_o), 0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr_i = AddrW'(i);
            #1 chk("abort_mem_zero", dbg_data_o, 0);
        end
        tick();
        chk("abort_no_done", 32'(done_cnt - dc0), 0);
        chk("abort_queue_drained", 32'(exp_q.size()), 0);

        // Start and clear together: clear wins
        start_i = 1; clr_i = 1;
        tick();
        start_i = 0; clr_i = 0;
        chk("start_clr_busy", 32'(busy_o), 0);
        tick();
        chk("start_clr_busy_later", 32'(busy_o), 0);
        chk("start_clr_no_done", 32'(done_cnt - dc0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
